// File: rtl/fire_ctrl.sv
// fire_ctrl: turns a bouncy fire button into single, rate-limited shots.
// Button path: 2-flop synchronizer -> debouncer -> armed rising-edge request.
// A three-state FSM (IDLE / COOLDOWN / RELOAD) decides whether a request
// becomes a shot. It checks that the bullet spawn point lies inside the
// playfield and manages the magazine.
module fire_ctrl #(
  parameter int MAX_AMMO        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 25,
  parameter int RELOAD_CYCLES   = 200,
  parameter int TANK_SIZE       = 32,
  parameter int BULLET_SIZE     = 8,
  parameter int PLAY_LIMIT      = 480,
  localparam int AMMO_W         = $clog2(MAX_AMMO + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_raw,
  input  logic              game_over,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  logic [1:0]        tank_dir,
  output logic              fire,
  output logic [1:0]        bullet_direction,
  output logic [9:0]        init_x,
  output logic [9:0]        init_y,
  output logic [AMMO_W-1:0] ammo_count,
  output logic              ready,
  output logic              reloading,
  output logic              shot_blocked
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  CD_LOAD   = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RL_LOAD   = TMR_W'(RELOAD_CYCLES - 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(MAX_AMMO);
  localparam logic [AMMO_W-1:0] AMMO_ONE  = AMMO_W'(1);

  // Muzzle offsets: the bullet is centred on the tank edge it leaves from.
  localparam logic [10:0] CTR_OFF  = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] TANK_OFF = 11'(TANK_SIZE);
  localparam logic [10:0] BUL_OFF  = 11'(BULLET_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COOLDOWN = 2'b01,
    ST_RELOAD   = 2'b10
  } state_t;

  // A spawn coordinate is usable when it is non-negative (bit 10 clear in the
  // 11-bit result) and the whole bullet still fits inside the playfield.
  function automatic logic muzzle_in_range(input logic [10:0] coord);
    logic [11:0] far_edge;
    far_edge = {1'b0, coord} + 12'(BULLET_SIZE);
    return (coord[10] == 1'b0) && (far_edge <= 12'(PLAY_LIMIT));
  endfunction

  logic              sync1_r, sync2_r;
  logic              level_r, level_d_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [DB_W-1:0]   arm_cnt_r;
  logic              armed_r;
  logic              req_r;

  state_t            state_r, state_s;
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic [AMMO_W-1:0] ammo_r, ammo_s;
  logic              fire_r, fire_s;
  logic              blocked_r, blocked_s;
  logic [9:0]        init_x_r, init_x_s;
  logic [9:0]        init_y_r, init_y_s;
  logic [1:0]        dir_r, dir_s;
  logic              ready_r, ready_s;
  logic              reloading_r, reloading_s;

  logic [10:0]       muzzle_x_s, muzzle_y_s;
  logic              muzzle_ok_s;
  logic              accept_s;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: follow the synchronized input only after it has disagreed for a full window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_r  <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
    end else if (sync2_r != level_r) begin
      if (db_cnt_r == DB_LAST) begin
        level_r  <= sync2_r;
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_r <= {DB_W{1'b0}};
    end
  end

  // Arming: needs a full window of released button after reset, so a button held through reset cannot fire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arm_cnt_r <= {DB_W{1'b0}};
      armed_r   <= 1'b0;
    end else if (armed_r) begin
      arm_cnt_r <= {DB_W{1'b0}};
    end else if (!level_r && !sync2_r) begin
      if (arm_cnt_r == DB_LAST) begin
        armed_r <= 1'b1;
      end else begin
        arm_cnt_r <= arm_cnt_r + DB_W'(1);
      end
    end else begin
      arm_cnt_r <= {DB_W{1'b0}};
    end
  end

  // Registered one-cycle request on each armed press of the debounced button.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_d_r <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      level_d_r <= level_r;
      req_r     <= level_r & ~level_d_r & armed_r;
    end
  end

  // Spawn position for the current tank pose, and whether it lies in the playfield.
  always_comb begin
    muzzle_x_s = {1'b0, tank_x} + TANK_OFF;
    muzzle_y_s = {1'b0, tank_y} + CTR_OFF;
    case (tank_dir)
      2'b00: begin
        muzzle_x_s = {1'b0, tank_x} + CTR_OFF;
        muzzle_y_s = {1'b0, tank_y} - BUL_OFF;
      end
      2'b01: begin
        muzzle_x_s = {1'b0, tank_x} + CTR_OFF;
        muzzle_y_s = {1'b0, tank_y} + TANK_OFF;
      end
      2'b10: begin
        muzzle_x_s = {1'b0, tank_x} - BUL_OFF;
        muzzle_y_s = {1'b0, tank_y} + CTR_OFF;
      end
      2'b11: begin
        muzzle_x_s = {1'b0, tank_x} + TANK_OFF;
        muzzle_y_s = {1'b0, tank_y} + CTR_OFF;
      end
      default: begin
        muzzle_x_s = {1'b0, tank_x} + TANK_OFF;
        muzzle_y_s = {1'b0, tank_y} + CTR_OFF;
      end
    endcase
    muzzle_ok_s = muzzle_in_range(muzzle_x_s) && muzzle_in_range(muzzle_y_s);
  end

  // Next-state logic: shot acceptance, cooldown and reload timing, magazine bookkeeping.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    ammo_s    = ammo_r;
    fire_s    = 1'b0;
    blocked_s = 1'b0;
    init_x_s  = init_x_r;
    init_y_s  = init_y_r;
    dir_s     = dir_r;
    accept_s  = req_r && (state_r == ST_IDLE) && !game_over;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (muzzle_ok_s) begin
            fire_s   = 1'b1;
            init_x_s = muzzle_x_s[9:0];
            init_y_s = muzzle_y_s[9:0];
            dir_s    = tank_dir;
            ammo_s   = ammo_r - AMMO_ONE;
            if (ammo_r == AMMO_ONE) begin
              state_s = ST_RELOAD;
              timer_s = RL_LOAD;
            end else begin
              state_s = ST_COOLDOWN;
              timer_s = CD_LOAD;
            end
          end else begin
            blocked_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TMR_W'(1);
        end
      end
      ST_RELOAD: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_s = ST_IDLE;
          ammo_s  = AMMO_FULL;
        end else begin
          timer_s = timer_r - TMR_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = {TMR_W{1'b0}};
      end
    endcase
    ready_s     = (state_s == ST_IDLE);
    reloading_s = (state_s == ST_RELOAD);
  end

  // State and output registers; reset aborts any timer and refills the magazine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= {TMR_W{1'b0}};
      ammo_r      <= AMMO_FULL;
      fire_r      <= 1'b0;
      blocked_r   <= 1'b0;
      init_x_r    <= 10'd0;
      init_y_r    <= 10'd0;
      dir_r       <= 2'b00;
      ready_r     <= 1'b1;
      reloading_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      ammo_r      <= ammo_s;
      fire_r      <= fire_s;
      blocked_r   <= blocked_s;
      init_x_r    <= init_x_s;
      init_y_r    <= init_y_s;
      dir_r       <= dir_s;
      ready_r     <= ready_s;
      reloading_r <= reloading_s;
    end
  end

  assign fire             = fire_r;
  assign shot_blocked     = blocked_r;
  assign init_x           = init_x_r;
  assign init_y           = init_y_r;
  assign bullet_direction = dir_r;
  assign ammo_count       = ammo_r;
  assign ready            = ready_r;
  assign reloading        = reloading_r;

endmodule

// File: tb/tb_fire_ctrl.sv
// Scoreboard bench for fire_ctrl. Stimulus pushes cycle-stamped expected
// shot events and status snapshots; a monitor compares them on falling edges.
module tb_fire_ctrl;

  localparam int DB = 4;
  localparam int CD = 10;
  localparam int RL = 50;
  localparam int MA = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_raw;
  logic       game_over;
  logic [9:0] tank_x, tank_y;
  logic [1:0] tank_dir;
  logic       fire;
  logic [1:0] bullet_direction;
  logic [9:0] init_x, init_y;
  logic [3:0] ammo_count;
  logic       ready, reloading, shot_blocked;

  fire_ctrl #(
    .MAX_AMMO(MA), .DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(CD), .RELOAD_CYCLES(RL),
    .TANK_SIZE(32), .BULLET_SIZE(8), .PLAY_LIMIT(480)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .game_over(game_over),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .fire(fire), .bullet_direction(bullet_direction),
    .init_x(init_x), .init_y(init_y), .ammo_count(ammo_count),
    .ready(ready), .reloading(reloading), .shot_blocked(shot_blocked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int is_fire; int x; int y; int d; int ammo; } ev_t;
  typedef struct { int cyc; int rdy; int rel; int ammo; int x; int y; int d; } st_t;

  ev_t evq[$];
  st_t stq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  stim_done = 1'b0;

  int m_ammo = MA;
  int m_x = 0, m_y = 0, m_d = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_st(input int c, input int rdy, input int rel, input int ammo,
                         input int x, input int y, input int d);
    st_t s;
    s = '{c, rdy, rel, ammo, x, y, d};
    stq.push_back(s);
  endtask

  // One press of four cycles; the event is due 8 cycles after the rise.
  task automatic shot(input int tx, input int ty, input int d, input int ex, input int ey,
                      input bit ok, input int gap);
    int k;
    ev_t e;
    tank_x   = 10'(tx);
    tank_y   = 10'(ty);
    tank_dir = 2'(d);
    k = cyc;
    if (ok) begin
      m_ammo--;
      m_x = ex; m_y = ey; m_d = d;
      e = '{k + 8, 1, ex, ey, d, m_ammo};
      evq.push_back(e);
      push_st(k + 8, 0, (m_ammo == 0) ? 1 : 0, m_ammo, m_x, m_y, m_d);
    end else begin
      e = '{k + 8, 0, 0, 0, 0, m_ammo};
      evq.push_back(e);
      push_st(k + 8, 1, 0, m_ammo, m_x, m_y, m_d);
    end
    btn_raw = 1'b1;
    tick(4);
    btn_raw = 1'b0;
    tick(gap - 4);
  endtask

  // Monitor: match shot/blocked events and status snapshots on falling edges.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (fire || shot_blocked) begin
        if (evq.size() == 0) begin
          chk("unexpected_event", int'(fire | shot_blocked), 0);
        end else begin
          e = evq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_fire", int'(fire), e.is_fire);
          chk("event_blocked", int'(shot_blocked), 1 - e.is_fire);
          if (e.is_fire != 0) begin
            chk("init_x", int'(init_x), e.x);
            chk("init_y", int'(init_y), e.y);
            chk("bullet_direction", int'(bullet_direction), e.d);
            chk("ammo_at_fire", int'(ammo_count), e.ammo);
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
        chk("missed_event", int'(fire | shot_blocked), 1);
        e = evq.pop_front();
      end
      for (int i = stq.size() - 1; i >= 0; i--) begin
        if (stq[i].cyc <= cyc) begin
          chk("status_ready", int'(ready), stq[i].rdy);
          chk("status_reloading", int'(reloading), stq[i].rel);
          chk("status_ammo", int'(ammo_count), stq[i].ammo);
          chk("status_init_x", int'(init_x), stq[i].x);
          chk("status_init_y", int'(init_y), stq[i].y);
          chk("status_dir", int'(bullet_direction), stq[i].d);
          stq.delete(i);
        end
      end
      if (stim_done) begin
        chk("events_left", evq.size(), 0);
        chk("status_left", stq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    reset_n = 1'b0; btn_raw = 1'b0; game_over = 1'b0;
    tank_x = 10'd0; tank_y = 10'd0; tank_dir = 2'b00;
    push_st(2, 1, 0, 8, 0, 0, 0);             // during reset
    push_st(4, 1, 0, 8, 0, 0, 0);             // first edge after release
    while (cyc < 3) @(negedge clk);
    reset_n = 1'b1;
    tick(10);

    // Clean press, tank (100,200) facing right: fire 8 cycles after the rise.
    k = cyc;
    push_st(k + 7, 1, 0, 8, 0, 0, 0);
    push_st(k + 17, 0, 0, 7, 132, 212, 3);    // last cooldown cycle
    push_st(k + 18, 1, 0, 7, 132, 212, 3);    // back to idle
    shot(100, 200, 3, 132, 212, 1'b1, 30);

    // Three-cycle glitch is filtered out.
    btn_raw = 1'b1; tick(3); btn_raw = 1'b0;
    tick(15);
    push_st(cyc + 1, 1, 0, 7, 132, 212, 3);
    tick(5);

    // Shot facing down, then a press whose request lands in the last cooldown cycle.
    k = cyc;
    shot(50, 60, 1, 62, 92, 1'b1, 10);        // fire at k+8
    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 2'b11;
    btn_raw = 1'b1; tick(4); btn_raw = 1'b0;
    push_st(k + 18, 1, 0, 6, 62, 92, 1);
    tick(30);
    push_st(cyc + 1, 1, 0, 6, 62, 92, 1);
    tick(2);

    // Playfield boundaries, then empty the magazine.
    shot(8,   300, 2, 0,   312, 1'b1, 25);
    shot(7,   300, 2, 0,   0,   1'b0, 25);
    shot(440, 100, 3, 472, 112, 1'b1, 25);
    shot(441, 100, 3, 0,   0,   1'b0, 25);
    shot(200, 8,   0, 212, 0,   1'b1, 25);
    shot(100, 4,   0, 0,   0,   1'b0, 25);
    shot(300, 440, 1, 312, 472, 1'b1, 25);
    shot(300, 441, 1, 0,   0,   1'b0, 25);
    shot(100, 200, 3, 132, 212, 1'b1, 25);
    k = cyc;
    push_st(k + 57, 0, 1, 0, 132, 212, 3);    // last reload cycle
    push_st(k + 58, 1, 0, 8, 132, 212, 3);    // refilled
    shot(100, 200, 3, 132, 212, 1'b1, 8);     // ammo 0, reload starts at k+8
    tick(60);
    m_ammo = MA;

    // game_over inhibits both a valid and a blocked shot.
    game_over = 1'b1;
    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 2'b11;
    btn_raw = 1'b1; tick(4); btn_raw = 1'b0; tick(21);
    tank_x = 10'd100; tank_y = 10'd4; tank_dir = 2'b00;
    btn_raw = 1'b1; tick(4); btn_raw = 1'b0; tick(21);
    push_st(cyc + 1, 1, 0, 8, 132, 212, 3);
    tick(2);
    game_over = 1'b0;

    // Button held through reset: nothing until released and pressed again.
    reset_n = 1'b0; btn_raw = 1'b1;
    m_ammo = MA; m_x = 0; m_y = 0; m_d = 0;
    tick(3);
    reset_n = 1'b1;
    push_st(cyc + 1, 1, 0, 8, 0, 0, 0);
    tick(20);
    btn_raw = 1'b0;
    tick(20);
    push_st(cyc + 1, 1, 0, 8, 0, 0, 0);
    tick(2);
    shot(100, 200, 3, 132, 212, 1'b1, 25);

    // Empty the magazine again and reset in the middle of reload.
    for (int i = 0; i < 6; i++) shot(100, 200, 3, 132, 212, 1'b1, 25);
    k = cyc;
    push_st(k + 27, 0, 1, 0, 132, 212, 3);    // reload cycle 19
    shot(100, 200, 3, 132, 212, 1'b1, 28);    // now at reload cycle 20
    reset_n = 1'b0;
    m_ammo = MA; m_x = 0; m_y = 0; m_d = 0;
    push_st(k + 29, 1, 0, 8, 0, 0, 0);
    tick(2);
    reset_n = 1'b1;
    push_st(k + 31, 1, 0, 8, 0, 0, 0);
    tick(10);
    stim_done = 1'b1;
  end

endmodule
